imem_responder: RTL and testbench

Instruction-memory responder serving the core's fetch port. The fetch stage issues word addresses over a valid/ready request channel. This block returns the stored 32-bit instruction over a valid/ready response channel, with 1-cycle latency and a 2-entry response buffer for backpressure. A side load port lets the bench or boot logic rewrite program words at run time.

---
 rtl/imem_responder.sv | 103 ++++++++++
 tb/tb_imem_responder.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_responder.sv
// Instruction-memory responder: valid/ready fetch requests in, stored words out
// through a 2-entry in-order response buffer, with a run-time program load port.
module imem_responder #(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [31:0]   req_addr,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [31:0]   rsp_data,
    output logic          rsp_err,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [31:0]   load_data,
    output logic [15:0]   err_count
);

    localparam logic [31:0] BOOT_WORD0 = 32'h0050_0113;
    localparam logic [31:0] BOOT_WORD1 = 32'h00a0_0193;
    localparam logic [31:0] NOP_WORD   = 32'h0000_0013;

    logic [31:0] mem_word [DEPTH];

    logic [31:0] data_reg [2];
    logic [1:0]  err_reg;
    logic        wr_ptr_reg;
    logic        rd_ptr_reg;
    logic [1:0]  count_reg;
    logic [15:0] err_count_reg;

    logic          push;
    logic          pop;
    logic          lookup_err;
    logic [AW-1:0] lookup_idx;
    logic [31:0]   lookup_data;

    // Each word is its own register so reset can restore the boot program.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
            localparam logic [31:0] RESET_WORD = (gi == 0) ? BOOT_WORD0 :
                                                 (gi == 1) ? BOOT_WORD1 : NOP_WORD;
            logic [31:0] word_reg;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    word_reg <= RESET_WORD;
                end else if (load_en && (load_addr == AW'(gi))) begin
                    word_reg <= load_data;
                end
            end

            assign mem_word[gi] = word_reg;
        end
    endgenerate

    assign req_ready = (count_reg != 2'd2);
    assign rsp_valid = (count_reg != 2'd0);
    assign push      = req_valid && req_ready;
    assign pop       = rsp_valid && rsp_ready;

    // Lookup reads the pre-edge word, so a same-cycle load is not seen.
    assign lookup_idx  = req_addr[AW+1:2];
    assign lookup_err  = (req_addr[1:0] != 2'b00) || (req_addr[31:2] >= 30'(DEPTH));
    assign lookup_data = lookup_err ? 32'h0 : mem_word[lookup_idx];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_reg[0]   <= 32'h0;
            data_reg[1]   <= 32'h0;
            err_reg       <= 2'b00;
            wr_ptr_reg    <= 1'b0;
            rd_ptr_reg    <= 1'b0;
            count_reg     <= 2'd0;
            err_count_reg <= 16'h0;
        end else begin
            if (push) begin
                data_reg[wr_ptr_reg] <= lookup_data;
                err_reg[wr_ptr_reg]  <= lookup_err;
                wr_ptr_reg           <= ~wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
                if (err_reg[rd_ptr_reg] && (err_count_reg != 16'hFFFF)) begin
                    err_count_reg <= err_count_reg + 16'd1;
                end
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 2'd1;
                2'b01:   count_reg <= count_reg - 2'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign rsp_data  = data_reg[rd_ptr_reg];
    assign rsp_err   = err_reg[rd_ptr_reg];
    assign err_count = err_count_reg;

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: reference-model scoreboard checked every cycle,
// table-driven directed fetches, backpressure/load/reset sequences, random stress.
module tb_imem_responder;

    localparam int DEPTH = 64;
    localparam int AW    = $clog2(DEPTH);

    typedef struct {
        logic [31:0] data;
        logic        err;
    } rsp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic [31:0]   req_addr;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_data;
    logic          rsp_err;
    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [31:0]   load_data;
    logic [15:0]   err_count;

    always #5 clk = ~clk;

    imem_responder #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data),
        .err_count (err_count)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] ref_mem [DEPTH];
    rsp_t        exp_q[$];
    rsp_t        got_q[$];
    logic [15:0] model_err = 16'h0;

    function automatic logic [31:0] boot_word(input int i);
        if (i == 0) return 32'h0050_0113;
        if (i == 1) return 32'h00a0_0193;
        return 32'h0000_0013;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Reference model and scoreboard, sampled mid-cycle away from the rising edge.
    always @(negedge clk) begin
        rsp_t e;
        rsp_t g;
        if (reset) begin
            check("rst_req_ready", req_ready, 1);
            check("rst_rsp_valid", rsp_valid, 0);
            check("rst_rsp_data", rsp_data, 0);
            check("rst_rsp_err", rsp_err, 0);
            check("rst_err_count", err_count, 0);
            for (int i = 0; i < DEPTH; i++) ref_mem[i] = boot_word(i);
            exp_q.delete();
            got_q.delete();
            model_err = 16'h0;
        end else begin
            check("rsp_valid", rsp_valid, exp_q.size() != 0);
            check("req_ready", req_ready, exp_q.size() < 2);
            check("err_count", err_count, model_err);
            if (rsp_valid && exp_q.size() > 0) begin
                check("head_data", rsp_data, exp_q[0].data);
                check("head_err", rsp_err, exp_q[0].err);
            end
            if (rsp_valid && rsp_ready && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.err && model_err != 16'hFFFF) model_err = model_err + 16'd1;
                g.data = rsp_data;
                g.err  = rsp_err;
                got_q.push_back(g);
            end
            if (req_valid && req_ready) begin
                e.err  = (req_addr % 4 != 0) || (req_addr >= 32'(4 * DEPTH));
                e.data = e.err ? 32'h0 : ref_mem[req_addr[AW+1:2]];
                exp_q.push_back(e);
            end
            if (load_en) ref_mem[load_addr] = load_data;
        end
    end

    // Holds req_valid until the DUT accepts; returns #1 after the accepting edge.
    task automatic wait_accept();
        bit ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] a);
        req_valid = 1'b1;
        req_addr  = a;
        wait_accept();
        req_valid = 1'b0;
    endtask

    task automatic expect_rsp(input string name, input logic [31:0] exp_data, input logic exp_err);
        rsp_t g;
        bit   ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            if (got_q.size() > 0) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
        end
        if (!ok) begin
            check({name, "_timeout"}, 0, 1);
        end else begin
            g = got_q.pop_front();
            $display("rsp %s: data=0x%08h err=%0b", name, g.data, g.err);
            check({name, "_data"}, g.data, exp_data);
            check({name, "_err"}, g.err, exp_err);
        end
        #1;
    endtask

    vec_t tv[8];
    int   n_err_exp;
    int   r;

    initial begin
        tv[0] = '{32'h0000_0000, 32'h0050_0113, 1'b0};
        tv[1] = '{32'h0000_0004, 32'h00a0_0193, 1'b0};
        tv[2] = '{32'h0000_0008, 32'h0000_0013, 1'b0};
        tv[3] = '{32'h0000_0002, 32'h0000_0000, 1'b1};
        tv[4] = '{32'(4 * DEPTH), 32'h0000_0000, 1'b1};
        tv[5] = '{32'h0000_0004, 32'h00a0_0193, 1'b0};
        tv[6] = '{32'(4 * DEPTH - 4), 32'h0000_0013, 1'b0};
        tv[7] = '{32'hFFFF_FFFC, 32'h0000_0000, 1'b1};

        reset     = 1'b1;
        req_valid = 1'b0;
        req_addr  = 32'h0;
        rsp_ready = 1'b1;
        load_en   = 1'b0;
        load_addr = '0;
        load_data = 32'h0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Directed fetches with the response side always ready.
        n_err_exp = 0;
        for (int i = 0; i < 8; i++) begin
            issue(tv[i].addr);
            expect_rsp($sformatf("vec%0d", i), tv[i].exp_data, tv[i].exp_err);
            if (tv[i].exp_err) n_err_exp++;
            check($sformatf("vec%0d_errcnt", i), err_count, n_err_exp);
        end

        // Backpressure: two accepted, third stalls until the first pop.
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_addr  = 32'h0;
        @(posedge clk); #1 req_addr = 32'h4;
        @(posedge clk); #1 req_addr = 32'h8;
        repeat (3) @(posedge clk);
        #1;
        check("bp_full_ready", req_ready, 0);
        check("bp_head_valid", rsp_valid, 1);
        check("bp_head_data", rsp_data, 32'h0050_0113);
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_ready_before_pop", req_ready, 0);
        @(posedge clk); #1;
        check("bp_ready_after_pop", req_ready, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        expect_rsp("bp0", 32'h0050_0113, 1'b0);
        expect_rsp("bp1", 32'h00a0_0193, 1'b0);
        expect_rsp("bp2", 32'h0000_0013, 1'b0);

        // Load and read of the same word in one cycle: read sees the old value.
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_addr  = 32'h4;
        load_en   = 1'b1;
        load_addr = AW'(1);
        load_data = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        load_en   = 1'b0;
        expect_rsp("ld_same", 32'h00a0_0193, 1'b0);
        issue(32'h4);
        expect_rsp("ld_after", 32'hDEAD_BEEF, 1'b0);

        // Reset with a full buffer and a modified program word.
        rsp_ready = 1'b0;
        issue(32'h0);
        issue(32'h4);
        load_en   = 1'b1;
        load_addr = AW'(1);
        load_data = 32'h1234_5678;
        @(posedge clk); #1;
        load_en = 1'b0;
        reset   = 1'b1;
        #1;
        check("mid_rst_valid", rsp_valid, 0);
        check("mid_rst_ready", req_ready, 1);
        check("mid_rst_errcnt", err_count, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        rsp_ready = 1'b1;
        issue(32'h4);
        expect_rsp("post_rst", 32'h00a0_0193, 1'b0);

        // Random stress; the scoreboard checks ordering, loss and head stability.
        for (int c = 0; c < 10000; c++) begin
            req_valid = ($urandom_range(0, 1) == 1);
            r = $urandom_range(0, 9);
            if (r < 8)       req_addr = 32'($urandom_range(0, DEPTH - 1)) << 2;
            else if (r == 8) req_addr = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
            else             req_addr = 32'(4 * DEPTH) + (32'($urandom_range(0, 1000)) << 2);
            rsp_ready = ($urandom_range(0, 3) != 0);
            load_en   = ($urandom_range(0, 7) == 0);
            load_addr = AW'($urandom_range(0, DEPTH - 1));
            load_data = $urandom;
            @(posedge clk); #1;
            if (got_q.size() > 64) got_q.delete();
        end
        req_valid = 1'b0;
        load_en   = 1'b0;
        rsp_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("drain_valid", rsp_valid, 0);
        check("drain_ready", req_ready, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
